// File: rtl/key_move_request.sv
// Left/right push-button conditioning: synchronise, debounce, arbitrate the
// last-pressed key and publish frame-stable active-low move requests.

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic db_n
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            db_n  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            // Any cycle where the level agrees with the accepted state restarts the qualification run
            if (sync2 == db_n) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_n <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module key_move_request #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic keyLeftN,
    input  logic keyRightN,
    output logic moveLeft,
    output logic moveRight,
    output logic bothHeld
);
    typedef enum logic [1:0] {
        LAST_NONE,
        LAST_LEFT,
        LAST_RIGHT
    } last_t;

    last_t last;
    logic  left_db_n, right_db_n;
    logic  left_db_q, right_db_q;
    logic  left_held, right_held;
    logic  left_press, right_press;
    logic  left_release, right_release;
    logic  req_left, req_right;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk   (clk),
        .rst_n (resetN),
        .key_n (keyLeftN),
        .db_n  (left_db_n)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk   (clk),
        .rst_n (resetN),
        .key_n (keyRightN),
        .db_n  (right_db_n)
    );

    always_comb begin
        left_held     = !left_db_n;
        right_held    = !right_db_n;
        left_press    = left_db_q && !left_db_n;
        right_press   = right_db_q && !right_db_n;
        left_release  = !left_db_q && left_db_n;
        right_release = !right_db_q && right_db_n;
        req_left      = left_held && (!right_held || last == LAST_LEFT);
        req_right     = right_held && (!left_held || last == LAST_RIGHT);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            left_db_q  <= 1'b1;
            right_db_q <= 1'b1;
            last       <= LAST_NONE;
            moveLeft   <= 1'b1;
            moveRight  <= 1'b1;
            bothHeld   <= 1'b0;
        end else begin
            left_db_q  <= left_db_n;
            right_db_q <= right_db_n;

            // Simultaneous presses cancel; a release hands ownership to whichever key remains held
            if (left_press && right_press) begin
                last <= LAST_NONE;
            end else if (left_press) begin
                last <= LAST_LEFT;
            end else if (right_press) begin
                last <= LAST_RIGHT;
            end else if (left_release || right_release) begin
                if (left_held) begin
                    last <= LAST_LEFT;
                end else if (right_held) begin
                    last <= LAST_RIGHT;
                end else begin
                    last <= LAST_NONE;
                end
            end

            if (startOfFrame) begin
                moveLeft  <= !req_left;
                moveRight <= !req_right;
                bothHeld  <= left_held && right_held;
            end
        end
    end
endmodule

// File: tb/tb_key_move_request.sv
// Randomised and directed bench for key_move_request against a cycle-level
// behavioural model of the key conditioning rules.

module tb_key_move_request;
    localparam int D     = 4;
    localparam int FRAME = 20;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame;
    logic keyLeftN = 1'b1;
    logic keyRightN = 1'b1;
    logic moveLeft, moveRight, bothHeld;

    int fcnt = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) fcnt <= (fcnt == FRAME - 1) ? 0 : fcnt + 1;
    assign startOfFrame = (fcnt == FRAME - 1);

    key_move_request #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .keyLeftN     (keyLeftN),
        .keyRightN    (keyRightN),
        .moveLeft     (moveLeft),
        .moveRight    (moveRight),
        .bothHeld     (bothHeld)
    );

    // Model state; index 0 = left, 1 = right. last: 0 none, 1 left, 2 right.
    typedef struct packed {
        logic [1:0]      s1;
        logic [1:0]      s2;
        logic [1:0]      db;
        logic [1:0]      dbp;
        logic [1:0][7:0] run;
        logic [1:0]      last;
        logic            ml;
        logic            mr;
        logic            bh;
    } model_t;

    model_t m;

    always @(posedge clk or negedge resetN) begin : model
        model_t     n;
        logic       l_held, r_held, press_l, press_r, rel_l, rel_r;
        logic [1:0] dir;
        n = m;
        dir = 2'd0;
        if (!resetN) begin
            n.s1 = 2'b11; n.s2 = 2'b11; n.db = 2'b11; n.dbp = 2'b11;
            n.run = '0; n.last = 2'd0;
            n.ml = 1'b1; n.mr = 1'b1; n.bh = 1'b0;
        end else begin
            l_held = !m.db[0];
            r_held = !m.db[1];
            if (startOfFrame) begin
                if (l_held && r_held) dir = m.last;
                else if (l_held)      dir = 2'd1;
                else if (r_held)      dir = 2'd2;
                n.ml = (dir != 2'd1);
                n.mr = (dir != 2'd2);
                n.bh = l_held && r_held;
            end
            press_l = m.dbp[0] && !m.db[0];
            press_r = m.dbp[1] && !m.db[1];
            rel_l   = !m.dbp[0] && m.db[0];
            rel_r   = !m.dbp[1] && m.db[1];
            if (press_l && press_r)  n.last = 2'd0;
            else if (press_l)        n.last = 2'd1;
            else if (press_r)        n.last = 2'd2;
            else if (rel_l || rel_r) n.last = l_held ? 2'd1 : (r_held ? 2'd2 : 2'd0);
            n.dbp = m.db;
            for (int k = 0; k < 2; k++) begin
                if (m.s2[k] != m.db[k]) begin
                    if (int'(m.run[k]) + 1 == D) begin
                        n.db[k]  = m.s2[k];
                        n.run[k] = 8'd0;
                    end else begin
                        n.run[k] = m.run[k] + 8'd1;
                    end
                end else begin
                    n.run[k] = 8'd0;
                end
            end
            n.s2 = m.s1;
            n.s1 = {keyRightN, keyLeftN};
        end
        m <= n;
    end

    always @(negedge clk) begin
        vectors++;
        if ({moveLeft, moveRight, bothHeld} !== {m.ml, m.mr, m.bh} || (!moveLeft && !moveRight)) begin
            miscompares++;
            $display("FAIL cycle_compare t=%0t: got ml/mr/bh=%b%b%b, expected %b%b%b",
                     $time, moveLeft, moveRight, bothHeld, m.ml, m.mr, m.bh);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < FRAME + 1; i++) begin
            @(posedge clk);
            #2;
            if (fcnt == 0) break;
        end
    endtask

    initial begin : stim
        int rem_l;
        int rem_r;
        rem_l = 0;
        rem_r = 0;

        cycles(3);
        resetN = 1'b1;

        // Idle
        cycles(3 * FRAME);
        check("idle_ml", moveLeft, 1'b1);
        check("idle_mr", moveRight, 1'b1);
        check("idle_bh", bothHeld, 1'b0);

        // Clean left press at frame cycle 3; debounced by cycle 9, published at next frame edge
        to_frame_start();
        cycles(3);
        keyLeftN = 1'b0;
        cycles(16);
        check("press_before_frame_ml", moveLeft, 1'b1);
        cycles(1);
        check("press_after_frame_ml", moveLeft, 1'b0);
        check("press_after_frame_mr", moveRight, 1'b1);
        keyLeftN = 1'b1;
        cycles(2 * FRAME);
        check("release_ml", moveLeft, 1'b1);

        // Bounce rejection on right
        keyRightN = 1'b0; cycles(2);
        keyRightN = 1'b1; cycles(2);
        keyRightN = 1'b0; cycles(2);
        keyRightN = 1'b1;
        cycles(2 * FRAME);
        check("bounce_mr", moveRight, 1'b1);

        // Last-pressed wins
        keyLeftN = 1'b0;
        cycles(10);
        keyRightN = 1'b0;
        cycles(2 * FRAME);
        check("lastwin_ml", moveLeft, 1'b1);
        check("lastwin_mr", moveRight, 1'b0);
        check("lastwin_bh", bothHeld, 1'b1);
        keyRightN = 1'b1;
        cycles(2 * FRAME);
        check("lastwin_rel_ml", moveLeft, 1'b0);
        check("lastwin_rel_bh", bothHeld, 1'b0);
        keyLeftN = 1'b1;
        cycles(2 * FRAME);

        // Simultaneous press
        keyLeftN = 1'b0;
        keyRightN = 1'b0;
        cycles(2 * FRAME);
        check("tie_ml", moveLeft, 1'b1);
        check("tie_mr", moveRight, 1'b1);
        check("tie_bh", bothHeld, 1'b1);
        keyLeftN = 1'b1;
        cycles(2 * FRAME);
        check("tie_rel_mr", moveRight, 1'b0);
        check("tie_rel_ml", moveLeft, 1'b1);
        keyRightN = 1'b1;
        cycles(2 * FRAME);

        // Async reset with left published and a right count in flight
        keyLeftN = 1'b0;
        cycles(2 * FRAME);
        check("pre_reset_ml", moveLeft, 1'b0);
        to_frame_start();
        keyRightN = 1'b0;
        cycles(4);
        #1 resetN = 1'b0;
        #1;
        check("async_reset_ml", moveLeft, 1'b1);
        check("async_reset_mr", moveRight, 1'b1);
        check("async_reset_bh", bothHeld, 1'b0);
        keyRightN = 1'b1;
        cycles(2);
        resetN = 1'b1;
        cycles(2 * FRAME);
        check("post_reset_ml", moveLeft, 1'b0);
        keyLeftN = 1'b1;
        cycles(FRAME);

        // Randomised traffic: mix of bounces, long holds and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (rem_l == 0) begin
                keyLeftN = 1'($urandom_range(0, 1));
                rem_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 6));
            end
            if (rem_r == 0) begin
                keyRightN = 1'($urandom_range(0, 1));
                rem_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 6));
            end
            rem_l--;
            rem_r--;
            if ($urandom_range(0, 599) == 0) begin
                #1 resetN = 1'b0;
                cycles(2);
                resetN = 1'b1;
            end else begin
                cycles(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_move_request.md
# key_move_request

Input-conditioning stage directly upstream of the player-motion block. Takes the two raw, bouncing, asynchronous push-button levels for left and right, then synchronises, debounces and arbitrates them. Presents active-low `moveLeft` / `moveRight` requests that change only once per frame, so the motion integrator samples a clean, frame-stable value on every `startOfFrame` pulse.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive `clk` cycles a synchronised key level must hold before the debounced state accepts it; legal range ≥ 2.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `resetN` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `startOfFrame` in 1: one-cycle pulse at each frame start (same pulse the motion block uses).
- `keyLeftN` in 1: raw left button, active-low, asynchronous to `clk`, may bounce.
- `keyRightN` in 1: raw right button, active-low, asynchronous, may bounce.
- `moveLeft` out 1: active-low left request, frame-stable.
- `moveRight` out 1: active-low right request, frame-stable.
- `bothHeld` out 1: active-high, debounced left and right both pressed (status/debug), frame-stable.

## Operation
- Synchroniser: two flops per key; reset value 1 (released).
- Debouncer, one per key:
  - Debounced state `dbN` (reset 1) and counter of width `$clog2(DEBOUNCE_CYCLES+1)` (reset 0).
  - If sync level == `dbN`: counter cleared to 0.
  - Otherwise: counter increments. When it reaches `DEBOUNCE_CYCLES-1` and the level still differs, `dbN` takes the sync level and the counter clears.
  - Any return to `dbN` before that clears the counter (bounce rejected).
- Press edge per key is `dbN` falling (1→0), one cycle wide.
- Arbiter, register `last` ∈ {NONE, LEFT, RIGHT}, reset NONE:
  - Left press edge only → LEFT. Right press edge only → RIGHT.
  - Both press edges in the same cycle → NONE (tie, no winner).
  - Release of a key: if the other key is still held, `last` becomes the other key. If neither key is held, `last` becomes NONE.
- Requested direction (combinational):
  - Only left held → left. Only right held → right. Neither held → none.
  - Both held → the direction in `last`; none if `last` = NONE.
- Frame latch: on a cycle with `startOfFrame`=1, register `moveLeft` = !(req==left), `moveRight` = !(req==right), `bothHeld` = both held. Otherwise hold.
- Invariant: `moveLeft` and `moveRight` are never both 0.
- Reset values: `moveLeft`=1, `moveRight`=1, `bothHeld`=0. All internal state as listed above.

## Timing
- Raw key edge to `dbN` change: 2 sync cycles + `DEBOUNCE_CYCLES` cycles, given a bounce-free level after the edge.
- `dbN` change to arbiter/`last` update: 1 cycle.
- Outputs update on the clock edge where `startOfFrame`=1, so they are visible from the following cycle.
- The motion block sampling on the same pulse sees the previous frame's value. Effective request latency is one frame.
- Outputs are constant between consecutive `startOfFrame` pulses regardless of key activity.
- `startOfFrame` held high for multiple cycles: the latch tracks every such cycle (no edge detect). This is a legal but unused mode.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap.
- Async reset mid-debounce or mid-frame: all state returns to reset values immediately. The first output update after reset deassertion occurs at the next `startOfFrame`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `startOfFrame` every 20 cycles.
- Reset then idle: keys at 1 for 3 frames → `moveLeft`=1, `moveRight`=1, `bothHeld`=0 throughout.
- Clean left press: `keyLeftN` 1→0 at cycle 3 of a frame → `dbN` left falls 6 cycles later. `moveLeft`=0 from the cycle after the next `startOfFrame`, and stays 0 until release propagates the same way.
- Bounce rejection: `keyRightN` toggles 0,1,0,1 with 2-cycle periods, then returns to 1 → debounced right never changes, `moveRight` stays 1.
- Last-pressed wins: hold left, then press right 10 cycles later → after the next frame `moveRight`=0, `moveLeft`=1, `bothHeld`=1. Release right → the following frame gives `moveLeft`=0.
- Simultaneous press: both keys 1→0 in the same cycle → `last`=NONE, both outputs 1, `bothHeld`=1. Release left → next frame `moveRight`=0.
- Async reset mid-operation: assert `resetN`=0 while `moveLeft`=0 and a right debounce count is in progress → outputs 1/1/0 immediately. After deassertion with left still held, `moveLeft`=0 only after 2+4 cycles plus the next `startOfFrame`.
